// File: rtl/time_keeper_if.sv
// Control and time-of-day bus between the time keeper and its user/display side.
interface time_keeper_if;
    logic       set_mode;
    logic       inc_hour;
    logic       inc_min;
    logic [5:0] hour_out;
    logic [5:0] min_out;
    logic [5:0] sec_out;
    logic       sec_pulse;
    logic       day_wrap;

    // User/control side: drives mode and buttons, observes the time.
    modport master (
        output set_mode,
        output inc_hour,
        output inc_min,
        input  hour_out,
        input  min_out,
        input  sec_out,
        input  sec_pulse,
        input  day_wrap
    );

    // Time keeper side.
    modport slave (
        input  set_mode,
        input  inc_hour,
        input  inc_min,
        output hour_out,
        output min_out,
        output sec_out,
        output sec_pulse,
        output day_wrap
    );
endinterface

// File: rtl/time_keeper.sv
// 24-hour time-of-day counter: 1 Hz prescaler, cascaded sec/min/hour counters,
// and a set mode where synchronized push-button edges advance hours/minutes.
module time_keeper #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input logic          clk,
    input logic          rst_n,
    time_keeper_if.slave bus
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    hour_q, hour_d;
    logic          sec_pulse_q, sec_pulse_d;
    logic          day_wrap_q, day_wrap_d;

    // Bit 0 is the first synchronizer flop, bit 2 the edge-detect history flop.
    logic [2:0]    hour_sync_q;
    logic [2:0]    min_sync_q;

    logic tick;
    logic hour_edge;
    logic min_edge;
    logic sec_last;
    logic min_last;
    logic hour_last;

    assign hour_edge = hour_sync_q[1] & ~hour_sync_q[2];
    assign min_edge  = min_sync_q[1] & ~min_sync_q[2];

    assign sec_last  = (sec_q == 6'd59);
    assign min_last  = (min_q == 6'd59);
    assign hour_last = (hour_q == 6'd23);

    // set_mode as sampled at the edge overrides a coincident tick.
    assign tick = (prescaler_q == PRE_LAST) && !bus.set_mode;

    // Button synchronizers and edge history; run regardless of mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour_sync_q <= 3'b000;
            min_sync_q  <= 3'b000;
        end else begin
            hour_sync_q <= {hour_sync_q[1:0], bus.inc_hour};
            min_sync_q  <= {min_sync_q[1:0], bus.inc_min};
        end
    end

    // Next-state for prescaler, time counters and the one-cycle pulses.
    always_comb begin
        prescaler_d = prescaler_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        sec_pulse_d = tick;
        day_wrap_d  = tick & sec_last & min_last & hour_last;

        if (bus.set_mode) begin
            prescaler_d = '0;
            sec_d       = 6'd0;
            // Manual adjust never carries between fields.
            if (min_edge) begin
                min_d = min_last ? 6'd0 : min_q + 6'd1;
            end
            if (hour_edge) begin
                hour_d = hour_last ? 6'd0 : hour_q + 6'd1;
            end
        end else if (tick) begin
            prescaler_d = '0;
            if (sec_last) begin
                sec_d = 6'd0;
                if (min_last) begin
                    min_d  = 6'd0;
                    hour_d = hour_last ? 6'd0 : hour_q + 6'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else begin
            prescaler_d = prescaler_q + 1'b1;
        end
    end

    // Time state registers; reset abandons any partial second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= 6'd0;
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            sec_pulse_q <= sec_pulse_d;
            day_wrap_q  <= day_wrap_d;
        end
    end

    assign bus.hour_out  = hour_q;
    assign bus.min_out   = min_q;
    assign bus.sec_out   = sec_q;
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.day_wrap  = day_wrap_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with TICKS_PER_SEC = 4 and a queue of expected states.
module tb_time_keeper;

    logic clk;
    logic rst_n;

    time_keeper_if bus ();

    time_keeper #(
        .TICKS_PER_SEC(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       sp;
        logic       dw;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int wrap_cnt = 0;
    int p_base;
    int w_base;

    // Count pulses once per high cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.sec_pulse === 1'b1) pulse_cnt++;
        if (bus.day_wrap === 1'b1) wrap_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Push the expected state, advance n edges, then pop and compare.
    task automatic expect_after(input int n, input string tag, input int h, input int m,
                                input int s, input int sp, input int dw);
        exp_t e;
        exp_t p;
        e.tag = tag;
        e.h   = 6'(h);
        e.m   = 6'(m);
        e.s   = 6'(s);
        e.sp  = 1'(sp);
        e.dw  = 1'(dw);
        sb.push_back(e);
        step(n);
        p = sb.pop_front();
        checks++;
        assert ({bus.hour_out, bus.min_out, bus.sec_out, bus.sec_pulse, bus.day_wrap} ===
                {p.h, p.m, p.s, p.sp, p.dw})
        else begin
            errors++;
            $error("FAIL %s: got %0d:%0d:%0d sp=%0b dw=%0b, want %0d:%0d:%0d sp=%0b dw=%0b",
                   p.tag, bus.hour_out, bus.min_out, bus.sec_out, bus.sec_pulse,
                   bus.day_wrap, p.h, p.m, p.s, p.sp, p.dw);
        end
    endtask

    task automatic chk_cnt(input string tag, input int got, input int want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // One press: raw high for one sampled edge, then two edges for the update to land.
    task automatic press(input logic h, input logic m);
        bus.inc_hour = h;
        bus.inc_min  = m;
        step(1);
        bus.inc_hour = 1'b0;
        bus.inc_min  = 1'b0;
        step(2);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.set_mode = 1'b0;
        bus.inc_hour = 1'b0;
        bus.inc_min  = 1'b0;

        #12;
        expect_after(0, "reset", 0, 0, 0, 0, 0);

        // Release and run 240 cycles.
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        p_base = pulse_cnt;
        w_base = wrap_cnt;
        expect_after(3, "first_tick_pre", 0, 0, 0, 0, 0);
        expect_after(1, "first_tick", 0, 0, 1, 1, 0);
        expect_after(1, "pulse_one_cycle", 0, 0, 1, 0, 0);
        expect_after(235, "run_240", 0, 1, 0, 1, 0);
        expect_after(1, "run_241", 0, 1, 0, 0, 0);
        chk_cnt("pulses_240", pulse_cnt - p_base, 60);
        chk_cnt("no_wrap_240", wrap_cnt - w_base, 0);

        // Asynchronous reset, then mid-prescale reset at 00:00:07.
        rst_n = 1'b0;
        #1;
        expect_after(0, "async_rst", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_after(28, "at_7s", 0, 0, 7, 1, 0);
        expect_after(2, "mid_prescale", 0, 0, 7, 0, 0);
        rst_n = 1'b0;
        #1;
        expect_after(0, "rst_mid", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_after(3, "abandon_pre", 0, 0, 0, 0, 0);
        expect_after(1, "abandon_tick", 0, 0, 1, 1, 0);

        // Button held through reset release counts as one press.
        rst_n        = 1'b0;
        bus.set_mode = 1'b1;
        bus.inc_hour = 1'b1;
        #1;
        expect_after(0, "rst_hold", 0, 0, 0, 0, 0);
        p_base = pulse_cnt;
        w_base = wrap_cnt;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_after(1, "hold_r1", 0, 0, 0, 0, 0);
        expect_after(1, "hold_r2", 0, 0, 0, 0, 0);
        expect_after(1, "hold_r3", 1, 0, 0, 0, 0);
        expect_after(5, "hold_once", 1, 0, 0, 0, 0);
        bus.inc_hour = 1'b0;
        expect_after(2, "hold_release", 1, 0, 0, 0, 0);

        // Set 23:59 and run through the day wrap.
        for (int i = 0; i < 22; i++) press(1'b1, 1'b1);
        for (int i = 0; i < 37; i++) press(1'b0, 1'b1);
        expect_after(0, "set_2359", 23, 59, 0, 0, 0);
        chk_cnt("set_no_pulse", pulse_cnt - p_base, 0);
        bus.set_mode = 1'b0;
        expect_after(3, "exit_pre", 23, 59, 0, 0, 0);
        expect_after(1, "exit_tick", 23, 59, 1, 1, 0);
        expect_after(232, "at_235959", 23, 59, 59, 1, 0);
        expect_after(3, "pre_wrap", 23, 59, 59, 0, 0);
        expect_after(1, "wrap", 0, 0, 0, 1, 1);
        expect_after(1, "wrap_one_cycle", 0, 0, 0, 0, 0);
        chk_cnt("wrap_count", wrap_cnt - w_base, 1);

        // Reach 10:58:33, then adjust in set mode.
        bus.set_mode = 1'b1;
        expect_after(1, "enter_set", 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) press(1'b1, 1'b1);
        for (int i = 0; i < 48; i++) press(1'b0, 1'b1);
        bus.set_mode = 1'b0;
        expect_after(132, "run_to_105833", 10, 58, 33, 1, 0);
        bus.set_mode = 1'b1;
        expect_after(1, "set_sec_clear", 10, 58, 0, 0, 0);
        p_base = pulse_cnt;
        w_base = wrap_cnt;
        press(1'b0, 1'b1);
        expect_after(0, "min_59", 10, 59, 0, 0, 0);
        press(1'b0, 1'b1);
        expect_after(0, "min_wrap_no_carry", 10, 0, 0, 0, 0);
        press(1'b0, 1'b1);
        expect_after(0, "min_1", 10, 1, 0, 0, 0);
        for (int i = 0; i < 13; i++) press(1'b1, 1'b0);
        expect_after(0, "hour_23", 23, 1, 0, 0, 0);
        press(1'b1, 1'b0);
        expect_after(0, "hour_wrap", 0, 1, 0, 0, 0);
        chk_cnt("adjust_no_pulse", pulse_cnt - p_base, 0);
        chk_cnt("adjust_no_wrap", wrap_cnt - w_base, 0);

        // inc_min held for 20 cycles gives one increment at N+2.
        bus.inc_min = 1'b1;
        expect_after(1, "held_n", 0, 1, 0, 0, 0);
        expect_after(1, "held_n1", 0, 1, 0, 0, 0);
        expect_after(1, "held_n2", 0, 2, 0, 0, 0);
        expect_after(17, "held_20", 0, 2, 0, 0, 0);
        bus.inc_min = 1'b0;
        expect_after(2, "held_release", 0, 2, 0, 0, 0);

        // Presses in run mode are discarded.
        bus.set_mode = 1'b0;
        press(1'b1, 1'b1);
        expect_after(0, "run_press", 0, 2, 0, 0, 0);
        expect_after(1, "run_press_tick", 0, 2, 1, 1, 0);

        // Simultaneous presses apply on the same edge.
        bus.set_mode = 1'b1;
        expect_after(1, "sim_enter", 0, 2, 0, 0, 0);
        bus.inc_hour = 1'b1;
        bus.inc_min  = 1'b1;
        expect_after(1, "sim_n", 0, 2, 0, 0, 0);
        bus.inc_hour = 1'b0;
        bus.inc_min  = 1'b0;
        expect_after(1, "sim_n1", 0, 2, 0, 0, 0);
        expect_after(1, "sim_n2", 1, 3, 0, 0, 0);

        // set_mode rising on the tick edge suppresses the tick.
        bus.set_mode = 1'b0;
        expect_after(3, "coinc_pre", 1, 3, 0, 0, 0);
        bus.set_mode = 1'b1;
        expect_after(1, "coinc_suppressed", 1, 3, 0, 0, 0);
        expect_after(4, "coinc_hold", 1, 3, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
